// File: rtl/polylut_io_pkg.sv
// Shared widths and frame constants for the PolyLUT frame I/O wrapper.
package polylut_io_pkg;

  localparam int unsigned WORD_W          = 32;
  localparam int unsigned FRAME_W         = 1568;
  localparam int unsigned RES_W           = 20;
  localparam int unsigned NCLASS          = 10;
  localparam int unsigned SCORE_W         = 2;
  localparam int unsigned CLASS_W         = 4;
  localparam int unsigned WORDS_PER_FRAME = 49;
  localparam int unsigned CREDIT_DEPTH    = 2;
  localparam int unsigned CNT_W           = $clog2(WORDS_PER_FRAME);
  localparam int unsigned CREDIT_W        = $clog2(CREDIT_DEPTH + 1);
  localparam int unsigned QCNT_W          = $clog2(CREDIT_DEPTH + 1);

endpackage

// File: rtl/polylut_argmax.sv
// Combinational argmax over packed 2-bit class scores; ties pick the lowest index.
module polylut_argmax #(
  parameter int unsigned RES_W = polylut_io_pkg::RES_W
) (
  input  logic [RES_W-1:0] scores,
  output logic [3:0]       idx_c
);
  import polylut_io_pkg::*;

  logic [SCORE_W-1:0] best;

  // Strict greater-than keeps the earliest index on equal scores.
  always_comb begin
    best  = scores[SCORE_W-1:0];
    idx_c = '0;
    for (int k = 1; k < int'(NCLASS); k++) begin
      if (scores[k*SCORE_W +: SCORE_W] > best) begin
        best  = scores[k*SCORE_W +: SCORE_W];
        idx_c = 4'(k);
      end
    end
  end

endmodule

// File: rtl/polylut_frame_io.sv
// Frame assembler, latency-matched result capture and credit-controlled output queue.
// Define POLYLUT_ARGMAX_EN to compute m_class_o; otherwise it is tied to 0.
module polylut_frame_io #(
  parameter int unsigned WORD_W   = polylut_io_pkg::WORD_W,
  parameter int unsigned FRAME_W  = polylut_io_pkg::FRAME_W,
  parameter int unsigned RES_W    = polylut_io_pkg::RES_W,
  parameter int unsigned PIPE_LAT = 12
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [WORD_W-1:0]  s_data_i,
  input  logic               s_valid_i,
  input  logic               s_last_i,
  output logic               s_ready_o,
  output logic [FRAME_W-1:0] net_in_o,
  input  logic [RES_W-1:0]   net_out_i,
  output logic [RES_W-1:0]   m_scores_o,
  output logic [3:0]         m_class_o,
  output logic               m_valid_o,
  input  logic               m_ready_i,
  output logic               err_o
);
  import polylut_io_pkg::*;

  localparam int unsigned STAGE_W = (WORDS_PER_FRAME - 1) * WORD_W;

  logic [CNT_W-1:0]    beat_cnt_q;
  logic [STAGE_W-1:0]  stage_q;
  logic [FRAME_W-1:0]  frame_q;
  logic                fire_q;
  logic                err_q;
  logic                s_ready_q;
  logic [PIPE_LAT-1:0] vsr_q;
  logic [CREDIT_W-1:0] credit_q, credit_d;
  logic [QCNT_W-1:0]   qcnt_q, qcnt_d;
  logic                m_valid_q;
  logic [RES_W-1:0]    hd_scores_q, tl_scores_q;

  logic accept, last_beat, frame_ok, frame_bad, push, pop;

  assign accept    = s_valid_i & s_ready_q;
  assign last_beat = (beat_cnt_q == CNT_W'(WORDS_PER_FRAME - 1));
  assign frame_ok  = accept & last_beat & s_last_i;
  assign frame_bad = accept & (last_beat ^ s_last_i);
  assign push      = vsr_q[PIPE_LAT-1];
  assign pop       = m_valid_q & m_ready_i;

  // Beat assembly: early words land in staging, the final word completes the frame.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      beat_cnt_q <= '0;
      stage_q    <= '0;
      frame_q    <= '0;
      fire_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      fire_q <= frame_ok;
      err_q  <= frame_bad;
      if (frame_ok) begin
        frame_q    <= FRAME_W'({s_data_i, stage_q});
        beat_cnt_q <= '0;
      end else if (frame_bad) begin
        beat_cnt_q <= '0;
      end else if (accept) begin
        beat_cnt_q <= beat_cnt_q + 1'b1;
        for (int i = 0; i < int'(WORDS_PER_FRAME) - 1; i++) begin
          if (beat_cnt_q == CNT_W'(i)) stage_q[i*WORD_W +: WORD_W] <= s_data_i;
        end
      end
    end
  end

  // Fire valid travels alongside the network pipeline.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) vsr_q <= '0;
    else     vsr_q <= {vsr_q[PIPE_LAT-2:0], fire_q};
  end

  // Credits count queue slots not yet claimed by an in-flight or queued result.
  always_comb begin
    credit_d = credit_q;
    qcnt_d   = qcnt_q;
    if (fire_q && !pop)      credit_d = credit_q - 1'b1;
    else if (pop && !fire_q) credit_d = credit_q + 1'b1;
    if (push && !pop)        qcnt_d = qcnt_q + 1'b1;
    else if (pop && !push)   qcnt_d = qcnt_q - 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      credit_q  <= CREDIT_W'(CREDIT_DEPTH);
      qcnt_q    <= '0;
      m_valid_q <= 1'b0;
      s_ready_q <= 1'b0;
    end else begin
      credit_q  <= credit_d;
      qcnt_q    <= qcnt_d;
      m_valid_q <= (qcnt_d != '0);
      s_ready_q <= (credit_d != '0);
    end
  end

  // Two-entry queue as head/tail registers; the head feeds the outputs directly.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hd_scores_q <= '0;
      tl_scores_q <= '0;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (qcnt_q == '0) hd_scores_q <= net_out_i;
          else              tl_scores_q <= net_out_i;
        end
        2'b01: hd_scores_q <= tl_scores_q;
        2'b11: begin
          if (qcnt_q == QCNT_W'(1)) begin
            hd_scores_q <= net_out_i;
          end else begin
            hd_scores_q <= tl_scores_q;
            tl_scores_q <= net_out_i;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef POLYLUT_ARGMAX_EN
  logic [3:0] cls_c;
  logic [3:0] hd_cls_q, tl_cls_q;

  polylut_argmax #(.RES_W(RES_W)) u_argmax (
    .scores (net_out_i),
    .idx_c  (cls_c)
  );

  // Class rides with its scores through the queue.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hd_cls_q <= '0;
      tl_cls_q <= '0;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (qcnt_q == '0) hd_cls_q <= cls_c;
          else              tl_cls_q <= cls_c;
        end
        2'b01: hd_cls_q <= tl_cls_q;
        2'b11: begin
          if (qcnt_q == QCNT_W'(1)) begin
            hd_cls_q <= cls_c;
          end else begin
            hd_cls_q <= tl_cls_q;
            tl_cls_q <= cls_c;
          end
        end
        default: ;
      endcase
    end
  end

  assign m_class_o = hd_cls_q;
`else
  assign m_class_o = 4'd0;
`endif

  assign s_ready_o  = s_ready_q;
  assign net_in_o   = frame_q;
  assign m_scores_o = hd_scores_q;
  assign m_valid_o  = m_valid_q;
  assign err_o      = err_q;

endmodule

// File: tb/tb_polylut_frame_io.sv
// Directed self-checking bench for polylut_frame_io; the network is modelled as word 0 bits [19:0].
module tb_polylut_frame_io;

  localparam int unsigned WORD_W  = 32;
  localparam int unsigned FRAME_W = 1568;
  localparam int unsigned RES_W   = 20;
`ifdef POLYLUT_ARGMAX_EN
  localparam logic [3:0] CLS_MASK = 4'hF;
`else
  localparam logic [3:0] CLS_MASK = 4'h0;
`endif

  logic               clk, rst;
  logic [WORD_W-1:0]  s_data_i;
  logic               s_valid_i, s_last_i, s_ready_o;
  logic [FRAME_W-1:0] net_in_o;
  logic [RES_W-1:0]   net_out_i;
  logic [RES_W-1:0]   m_scores_o;
  logic [3:0]         m_class_o;
  logic               m_valid_o, m_ready_i, err_o;

  int n_checks = 0;
  int n_errors = 0;

  polylut_frame_io dut (
    .clk        (clk),
    .rst        (rst),
    .s_data_i   (s_data_i),
    .s_valid_i  (s_valid_i),
    .s_last_i   (s_last_i),
    .s_ready_o  (s_ready_o),
    .net_in_o   (net_in_o),
    .net_out_i  (net_out_i),
    .m_scores_o (m_scores_o),
    .m_class_o  (m_class_o),
    .m_valid_o  (m_valid_o),
    .m_ready_i  (m_ready_i),
    .err_o      (err_o)
  );

  assign net_out_i = net_in_o[RES_W-1:0];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [3:0] ecls(input logic [3:0] k);
    return k & CLS_MASK;
  endfunction

  // Waits for ready at the falling edge, presents the beat, returns 1ns after the accepting edge.
  task automatic send_beat(input logic [WORD_W-1:0] data, input logic last);
    int guard = 0;
    @(negedge clk);
    while (!s_ready_o && guard < 300) begin
      @(negedge clk);
      guard++;
    end
    if (!s_ready_o) check("ready_timeout", 64'(s_ready_o), 64'd1);
    s_data_i  = data;
    s_valid_i = 1'b1;
    s_last_i  = last;
    @(posedge clk);
    #1;
    s_valid_i = 1'b0;
    s_last_i  = 1'b0;
  endtask

  task automatic send_frame(input logic [WORD_W-1:0] w0, input int nbeats, input int last_at);
    for (int i = 0; i < nbeats; i++)
      send_beat((i == 0) ? w0 : WORD_W'(i), (i == last_at));
  endtask

  // Counts rising edges until m_valid_o is seen; -1 if the bound expires.
  task automatic wait_valid(output int lat);
    lat = -1;
    for (int c = 1; c <= 40; c++) begin
      @(posedge clk);
      #1;
      if (m_valid_o) begin
        lat = c;
        break;
      end
    end
  endtask

  task automatic pop_one();
    @(negedge clk);
    m_ready_i = 1'b1;
    @(posedge clk);
    #1;
    m_ready_i = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    int lat;
    int seen;
    rst = 1'b1; s_data_i = '0; s_valid_i = 1'b0; s_last_i = 1'b0; m_ready_i = 1'b0;
    idle(2);
    check("rst_s_ready", 64'(s_ready_o), 64'd0);
    check("rst_net_in", 64'(net_in_o[63:0]), 64'd0);
    check("rst_m_valid", 64'(m_valid_o), 64'd0);
    check("rst_err", 64'(err_o), 64'd0);
    check("rst_scores", 64'(m_scores_o), 64'd0);
    check("rst_class", 64'(m_class_o), 64'd0);
    rst = 1'b0;
    @(posedge clk); #1;
    check("ready_after_rst", 64'(s_ready_o), 64'd1);

    // Basic frame: word n = n
    send_frame(32'd0, 49, 48);
    check("basic_word1", 64'(net_in_o[63:32]), 64'd1);
    check("basic_word48", 64'(net_in_o[1567:1536]), 64'd48);
    check("basic_word0", 64'(net_in_o[31:0]), 64'd0);
    check("basic_err", 64'(err_o), 64'd0);
    wait_valid(lat);
    check("basic_latency", 64'(lat), 64'd13);
    check("basic_scores", 64'(m_scores_o), 64'd0);
    pop_one();
    check("basic_popped", 64'(m_valid_o), 64'd0);

    // Argmax: class 9 dominant, then a tie between 2 and 7
    send_frame(32'h000D_5555, 49, 48);
    wait_valid(lat);
    check("am9_latency", 64'(lat), 64'd13);
    check("am9_scores", 64'(m_scores_o), 64'h0D5555);
    check("am9_class", 64'(m_class_o), 64'(ecls(4'd9)));
    pop_one();
    send_frame(32'h0000_C030, 49, 48);
    wait_valid(lat);
    check("tie_scores", 64'(m_scores_o), 64'h0C030);
    check("tie_class", 64'(m_class_o), 64'(ecls(4'd2)));
    pop_one();

    // Early last on beat 10
    send_frame(32'h0000_0300, 11, 10);
    check("early_err_pulse", 64'(err_o), 64'd1);
    @(posedge clk); #1;
    check("early_err_clear", 64'(err_o), 64'd0);
    seen = 0;
    repeat (20) begin
      @(posedge clk); #1;
      if (m_valid_o) seen = 1;
    end
    check("early_no_result", 64'(seen), 64'd0);
    check("early_frame_held", 64'(net_in_o[31:0]), 64'h0C030);
    send_frame(32'h0000_0300, 49, 48);
    wait_valid(lat);
    check("after_err_latency", 64'(lat), 64'd13);
    check("after_err_scores", 64'(m_scores_o), 64'h00300);
    check("after_err_class", 64'(m_class_o), 64'(ecls(4'd4)));
    pop_one();

    // 49 beats without last
    send_frame(32'h0000_0002, 49, -1);
    check("nolast_err_pulse", 64'(err_o), 64'd1);
    check("nolast_frame_held", 64'(net_in_o[31:0]), 64'h00300);
    send_frame(32'h0000_0002, 49, 48);
    wait_valid(lat);
    check("nolast_recover_scores", 64'(m_scores_o), 64'h00002);
    pop_one();

    // Back-pressure across three frames
    send_frame(32'h0000_0001, 49, 48);
    idle(3);
    check("bp_ready_one_credit", 64'(s_ready_o), 64'd1);
    send_frame(32'h0000_0008, 49, 48);
    idle(3);
    check("bp_ready_dropped", 64'(s_ready_o), 64'd0);
    wait_valid(lat);
    idle(16);
    check("bp_head_a", 64'(m_scores_o), 64'h00001);
    fork
      send_frame(32'h0000_0020, 49, 48);
      begin
        idle(4);
        check("bp_still_blocked", 64'(s_ready_o), 64'd0);
        pop_one();
        check("bp_head_b", 64'(m_scores_o), 64'h00008);
        check("bp_class_b", 64'(m_class_o), 64'(ecls(4'd1)));
      end
    join
    idle(20);
    check("bp_hold_b", 64'(m_scores_o), 64'h00008);
    check("bp_hold_valid", 64'(m_valid_o), 64'd1);
    pop_one();
    check("bp_head_c", 64'(m_scores_o), 64'h00020);
    check("bp_class_c", 64'(m_class_o), 64'(ecls(4'd2)));
    pop_one();
    check("bp_empty", 64'(m_valid_o), 64'd0);

    // Reset 5 cycles after fire
    send_frame(32'h0000_0005, 49, 48);
    repeat (5) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    check("mid_rst_net_in", 64'(net_in_o[63:0]), 64'd0);
    check("mid_rst_valid", 64'(m_valid_o), 64'd0);
    check("mid_rst_ready", 64'(s_ready_o), 64'd0);
    check("mid_rst_scores", 64'(m_scores_o), 64'd0);
    idle(2);
    rst = 1'b0;
    seen = 0;
    repeat (30) begin
      @(posedge clk); #1;
      if (m_valid_o) seen = 1;
    end
    check("mid_rst_no_result", 64'(seen), 64'd0);
    check("mid_rst_ready_back", 64'(s_ready_o), 64'd1);
    send_frame(32'h0000_0001, 49, 48);
    idle(3);
    check("mid_rst_credit_1", 64'(s_ready_o), 64'd1);
    send_frame(32'h0000_0002, 49, 48);
    idle(3);
    check("mid_rst_credit_0", 64'(s_ready_o), 64'd0);
    wait_valid(lat);
    idle(16);
    check("mid_rst_head", 64'(m_scores_o), 64'h00001);
    pop_one();
    check("mid_rst_second", 64'(m_scores_o), 64'h00002);
    pop_one();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/polylut_frame_io.md
POLYLUT_FRAME_IO -- requirements
Module: polylut_frame_io

Interface
REQ-001 SHALL have parameter WORD_W, default 32, meaning the input stream word width in bits.
REQ-002 SHALL have parameter FRAME_W, default 1568, meaning the network input width (784 pixels x 2 bits).
REQ-003 SHALL have parameter RES_W, default 20, meaning the network output width (10 classes x 2-bit score).
REQ-004 SHALL have parameter PIPE_LAT, default 12, meaning the cycles from net_in_o change to a valid net_out_i.
REQ-005 SHALL have ports: clk in 1, the single clock; rst in 1, asynchronous active-high reset.
REQ-006 SHALL have ports: s_data_i in WORD_W, pixel word; s_valid_i in 1; s_last_i in 1, final word of frame; s_ready_o out 1.
REQ-007 SHALL have ports: net_in_o out FRAME_W, drives network M0; net_out_i in RES_W, driven by network M12.
REQ-008 SHALL have ports: m_scores_o out RES_W; m_class_o out 4; m_valid_o out 1; m_ready_i in 1; err_o out 1, one-cycle frame-error pulse.

Function
REQ-009 SHALL accept a stream beat when s_valid_i and s_ready_o are both high.
REQ-010 SHALL place beat n of a frame (n = 0..48) at net_in_o bits [32n+31:32n] once the frame completes; beat 0 is the least significant word.
REQ-011 SHALL treat a frame as complete on the beat with count 48 and s_last_i high, then load the frame register in the next cycle and issue one "fire" that cycle.
REQ-012 SHALL hold net_in_o constant between fires; only the fire cycle is tagged valid.
REQ-013 SHALL delay each fire by a PIPE_LAT-deep valid shift register, and capture net_out_i into the result queue in the cycle the tap asserts.
REQ-014 SHALL give the result queue depth 2 (FIFO order); m_valid_o is high whenever the queue is non-empty; a pop occurs on m_valid_o and m_ready_i.
REQ-015 SHALL maintain a credit counter, initial 2: decremented on fire, incremented on pop; on simultaneous fire and pop it is unchanged.
REQ-016 SHALL drive s_ready_o low while credits are 0, guaranteeing no captured result is ever dropped.
REQ-017 SHALL, on s_last_i at count not 48, or on count 48 without s_last_i, discard the partial frame, reset the beat count to 0, pulse err_o, and not fire.
REQ-018 SHALL set m_class_o to the index k (0..9) of the maximum 2-bit score at bits [2k+1:2k] of m_scores_o; ties resolve to the lowest index.
REQ-019 SHALL keep m_scores_o and m_class_o stable while m_valid_o is high and m_ready_i is low.

Reset
REQ-020 SHALL, on rst high, asynchronously clear the beat count, frame register (net_in_o = 0), valid shift register, queue, m_valid_o, m_scores_o, m_class_o, and err_o to 0, and set credits to 2.
REQ-021 SHALL drive s_ready_o low during reset and set it high from the first cycle after reset release.
REQ-022 SHALL discard any in-flight frames and partially assembled data when reset is asserted mid-operation, with no result emitted afterwards.

Configuration
REQ-023 SHALL compute m_class_o by argmax when POLYLUT_ARGMAX_EN is defined; otherwise m_class_o SHALL be tied to 0, the argmax logic SHALL be absent, and m_scores_o SHALL be unchanged.

Structure
REQ-024 SHALL take WORD_W, FRAME_W, RES_W, NCLASS=10, SCORE_W=2, the words-per-frame constant (49), and the credit depth (2) from shared package polylut_io_pkg.
REQ-025 SHALL implement argmax as combinational sub-module polylut_argmax (RES_W in, 4-bit index out).

Verification
REQ-026 SHALL verify that 49 beats with word n = n and last on beat 48 give fire; net_in_o[63:32] = 1; m_valid_o exactly PIPE_LAT+1 cycles after the last beat.
REQ-027 SHALL verify that net_out_i scores {9:3, others:1} give m_class_o = 9, and scores {2:3, 7:3} give m_class_o = 2.
REQ-028 SHALL verify that s_last_i on beat 10 gives an err_o pulse, no fire, and a following well-formed frame processed normally.
REQ-029 SHALL verify that with m_ready_i held low across 3 frames, s_ready_o drops after the 2nd fire, both results are retained in order, and the 3rd frame proceeds after a pop.
REQ-030 SHALL verify that rst asserted 5 cycles after fire gives outputs 0 immediately, no m_valid_o, and credits restored to 2.
